// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared parameters, FSM state type and pointer helpers for the FIR MAC sequencer
package fir_pkg;

  localparam int FILTER_ORDER     = 4;
  localparam int MEMORY_DELAY     = 2;
  localparam int MULT_ACC_LATENCY = 6;
  localparam int LINE_DEPTH       = FILTER_ORDER + 1;
  localparam int ADDR_W           = $clog2(LINE_DEPTH);
  localparam int CADDR_W          = $clog2(FILTER_ORDER);
  localparam int FILL_W           = $clog2(FILTER_ORDER + 1);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(LINE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] ptr_dec(input logic [ADDR_W-1:0] p);
    return (p == '0) ? ADDR_W'(LINE_DEPTH - 1) : p - 1'b1;
  endfunction

endpackage

// File: rtl/fir_shift_pipe.sv
// rtl/fir_shift_pipe.sv - fixed-depth shift register, asynchronously cleared to zero
module fir_shift_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q_o = stage[DEPTH-1];

endmodule

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - issues tap addresses and MAC controls for the shared FP FIR MAC
module fir_mac_sequencer
  import fir_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ce_i,
  output logic               sample_we_o,
  output logic [ADDR_W-1:0]  sample_waddr_o,
  output logic [ADDR_W-1:0]  sample_raddr_o,
  output logic [CADDR_W-1:0] coef_raddr_o,
  output logic               mac_en_o,
  output logic               mac_load_o,
  output logic               mac_zero_o,
  output logic               busy_o,
  output logic               drop_o,
  output logic               dv_o
);

  state_t              state, state_nxt;
  logic [CADDR_W-1:0]  k;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [FILL_W-1:0]   fill;
  logic                issuing, last_tap, accept;
  logic [2:0]          ctrl_issue;

  assign issuing  = (state == ISSUE);
  assign last_tap = issuing && (k == CADDR_W'(FILTER_ORDER - 1));
  assign accept   = ce_i && ((state == IDLE) || last_tap);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (last_tap) state_nxt = accept ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      k      <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      drop_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      drop_o <= ce_i && !accept;
      if (accept || last_tap) k <= '0;
      else if (issuing)       k <= k + 1'b1;
      // rd_ptr walks backwards from the newest sample: tap k reads base-k
      if (accept) begin
        wr_ptr <= ptr_inc(wr_ptr);
        rd_ptr <= wr_ptr;
        if (fill != FILL_W'(FILTER_ORDER)) fill <= fill + 1'b1;
      end else if (issuing) begin
        rd_ptr <= ptr_dec(rd_ptr);
      end
    end
  end

  assign sample_we_o    = accept;
  assign sample_waddr_o = wr_ptr;
  assign sample_raddr_o = rd_ptr;
  assign coef_raddr_o   = k;
  assign busy_o         = issuing;

  // slots beyond the fill level have never been written and must read as +0.0
  assign ctrl_issue = {issuing, issuing && (k == '0), issuing && (FILL_W'(k) >= fill)};

  fir_shift_pipe #(.WIDTH(3), .DEPTH(MEMORY_DELAY)) u_ctrl_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (ctrl_issue),
    .q_o   ({mac_en_o, mac_load_o, mac_zero_o})
  );

  // the last tap reaches the MAC after the memory delay, then the accumulator latency applies
  fir_shift_pipe #(.WIDTH(1), .DEPTH(MEMORY_DELAY + MULT_ACC_LATENCY)) u_dv_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (last_tap),
    .q_o   (dv_o)
  );

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - directed self-checking bench for fir_mac_sequencer
module tb_fir_mac_sequencer;
  import fir_pkg::*;

  logic               clk = 1'b0;
  logic               rst_i;
  logic               ce_i;
  logic               sample_we_o;
  logic [ADDR_W-1:0]  sample_waddr_o;
  logic [ADDR_W-1:0]  sample_raddr_o;
  logic [CADDR_W-1:0] coef_raddr_o;
  logic               mac_en_o, mac_load_o, mac_zero_o;
  logic               busy_o, drop_o, dv_o;

  fir_mac_sequencer dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .ce_i           (ce_i),
    .sample_we_o    (sample_we_o),
    .sample_waddr_o (sample_waddr_o),
    .sample_raddr_o (sample_raddr_o),
    .coef_raddr_o   (coef_raddr_o),
    .mac_en_o       (mac_en_o),
    .mac_load_o     (mac_load_o),
    .mac_zero_o     (mac_zero_o),
    .busy_o         (busy_o),
    .drop_o         (drop_o),
    .dv_o           (dv_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  bit                 ce_sched [64];
  logic [ADDR_W-1:0]  wa_log   [64];
  logic [ADDR_W-1:0]  sra_log  [64];
  logic [CADDR_W-1:0] coef_log [64];
  logic               we_log [64], en_log [64], load_log [64], zero_log [64];
  logic               busy_log [64], drop_log [64], dv_log [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    ce_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    for (int i = 0; i < 64; i++) ce_sched[i] = 1'b0;
  endtask

  // cycle c runs from just after posedge c to posedge c+1; outputs sampled at the negedge
  task automatic run(input int len);
    for (int c = 0; c < len; c++) begin
      ce_i = ce_sched[c];
      @(negedge clk);
      we_log[c]   = sample_we_o;
      wa_log[c]   = sample_waddr_o;
      sra_log[c]  = sample_raddr_o;
      coef_log[c] = coef_raddr_o;
      en_log[c]   = mac_en_o;
      load_log[c] = mac_load_o;
      zero_log[c] = mac_zero_o;
      busy_log[c] = busy_o;
      drop_log[c] = drop_o;
      dv_log[c]   = dv_o;
      @(posedge clk);
      #1;
    end
    ce_i = 1'b0;
  endtask

  function automatic int count_dv(input int len);
    int n = 0;
    for (int c = 0; c < len; c++) if (dv_log[c]) n++;
    return n;
  endfunction

  int exp_coef [4] = '{0, 1, 2, 3};
  int exp_sra  [4] = '{0, 4, 3, 2};

  initial begin
    // single sample
    do_reset();
    ce_sched[10] = 1'b1;
    run(30);
    chk("reset_outputs", {we_log[0], en_log[0], load_log[0], zero_log[0], busy_log[0],
                          drop_log[0], dv_log[0], coef_log[0], sra_log[0], wa_log[0]}, 0);
    chk("t1_we", we_log[10], 1);
    chk("t1_waddr", wa_log[10], 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t1_coef_k%0d", k), coef_log[11+k], exp_coef[k]);
      chk($sformatf("t1_sraddr_k%0d", k), sra_log[11+k], exp_sra[k]);
      chk($sformatf("t1_busy_k%0d", k), busy_log[11+k], 1);
    end
    chk("t1_busy_end", busy_log[15], 0);
    for (int c = 12; c < 18; c++) begin
      chk($sformatf("t1_en_c%0d", c), en_log[c], (c >= 13 && c <= 16));
      chk($sformatf("t1_load_c%0d", c), load_log[c], (c == 13));
      chk($sformatf("t1_zero_c%0d", c), zero_log[c], (c >= 14 && c <= 16));
    end
    for (int c = 0; c < 30; c++) chk($sformatf("t1_dv_c%0d", c), dv_log[c], (c == 22));

    // seven back-to-back samples every 4 cycles
    do_reset();
    for (int i = 0; i < 7; i++) ce_sched[10 + 4*i] = 1'b1;
    run(50);
    for (int c = 0; c < 50; c++) chk($sformatf("t2_drop_c%0d", c), drop_log[c], 0);
    for (int c = 12; c < 42; c++) chk($sformatf("t2_en_c%0d", c), en_log[c], (c >= 13 && c <= 40));
    for (int c = 0; c < 50; c++)
      chk($sformatf("t2_dv_c%0d", c), dv_log[c], (c >= 22 && c <= 46 && ((c - 22) % 4) == 0));
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("t2_waddr_a%0d", i), wa_log[10 + 4*i], i % 5);
      chk($sformatf("t2_load_a%0d", i), load_log[13 + 4*i], 1);
    end
    for (int k = 0; k < 4; k++) chk($sformatf("t2_wrap_sraddr_k%0d", k), sra_log[31+k], exp_sra[k]);
    chk("t2_zero_s2_k0", zero_log[17], 0);
    chk("t2_zero_s2_k1", zero_log[18], 0);
    chk("t2_zero_s2_k2", zero_log[19], 1);
    chk("t2_zero_s2_k3", zero_log[20], 1);
    for (int c = 25; c < 45; c++) chk($sformatf("t2_zero_full_c%0d", c), zero_log[c], 0);

    // second sample arrives mid-issue and is dropped
    do_reset();
    ce_sched[10] = 1'b1;
    ce_sched[12] = 1'b1;
    run(30);
    chk("t3_we_dropped", we_log[12], 0);
    for (int c = 0; c < 30; c++) chk($sformatf("t3_drop_c%0d", c), drop_log[c], (c == 13));
    chk("t3_dv_count", count_dv(30), 1);
    chk("t3_dv_c22", dv_log[22], 1);

    // asynchronous reset in the middle of a sample
    do_reset();
    ce_sched[10] = 1'b1;
    run(13);
    rst_i = 1'b1;
    #1;
    chk("t4_async_clear", {mac_en_o, mac_load_o, mac_zero_o, busy_o, dv_o, drop_o,
                           coef_raddr_o, sample_raddr_o, sample_waddr_o}, 0);
    do_reset();
    ce_sched[2] = 1'b1;
    run(20);
    chk("t4_we", we_log[2], 1);
    chk("t4_waddr", wa_log[2], 0);
    for (int c = 5; c < 9; c++) chk($sformatf("t4_zero_c%0d", c), zero_log[c], (c >= 6));
    for (int c = 0; c < 20; c++) chk($sformatf("t4_dv_c%0d", c), dv_log[c], (c == 14));

    // ce_i held high for 20 cycles
    do_reset();
    for (int c = 10; c < 30; c++) ce_sched[c] = 1'b1;
    run(45);
    for (int c = 10; c < 30; c++) chk($sformatf("t5_we_c%0d", c), we_log[c], (((c - 10) % 4) == 0));
    for (int c = 0; c < 45; c++)
      chk($sformatf("t5_drop_c%0d", c), drop_log[c],
          (c >= 11 && c <= 30 && ((c - 11) % 4) != 0));
    chk("t5_dv_count", count_dv(45), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t5_dv_a%0d", i), dv_log[22 + 4*i], 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
